// File: rtl/hdmi_clock_sequencer.sv
// HDMI clock bring-up sequencer: resets the PLL, waits for a settled lock, then
// releases the serializer and timing generator, retrying on timeout or lock loss.
module hdmi_clock_sequencer #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 65536,
    parameter int unsigned SETTLE_CYCLES  = 1024,
    parameter int unsigned UNLOCK_FILTER  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       tx_rst,
    output logic       video_en,
    output logic [2:0] state_o,
    output logic [7:0] relock_count,
    output logic [7:0] timeout_count
);

    localparam int unsigned CNT_W  = 17;
    localparam int unsigned FILT_W = $clog2(UNLOCK_FILTER + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLLRST    = 3'd1,
        WAIT_LOCK = 3'd2,
        SETTLE    = 3'd3,
        RUN       = 3'd4
    } state_t;

    state_t              state;
    state_t              state_n;
    logic                sync_1;
    logic                lock_s;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_n;
    logic [FILT_W-1:0]   filt;
    logic [FILT_W-1:0]   filt_n;
    logic                inc_timeout;
    logic                inc_relock;
    logic                pll_rst_n;
    logic                tx_rst_n;
    logic                video_en_n;
    logic [7:0]          relock_count_n;
    logic [7:0]          timeout_count_n;

    // Two-flop synchronizer for the asynchronous lock indication
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1 <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync_1 <= pll_locked;
            lock_s <= sync_1;
        end
    end

    // State register and all registered outputs/counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            filt          <= '0;
            pll_rst       <= 1'b1;
            tx_rst        <= 1'b1;
            video_en      <= 1'b0;
            relock_count  <= 8'd0;
            timeout_count <= 8'd0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            filt          <= filt_n;
            pll_rst       <= pll_rst_n;
            tx_rst        <= tx_rst_n;
            video_en      <= video_en_n;
            relock_count  <= relock_count_n;
            timeout_count <= timeout_count_n;
        end
    end

    // Next-state logic; dropping enable beats every other transition
    always_comb begin
        state_n     = state;
        inc_timeout = 1'b0;
        inc_relock  = 1'b0;
        if (state != IDLE && !enable) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) state_n = PLLRST;
                end
                PLLRST: begin
                    if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) state_n = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_n = SETTLE;
                    end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        state_n     = PLLRST;
                        inc_timeout = 1'b1;
                    end
                end
                SETTLE: begin
                    if (!lock_s) begin
                        state_n = WAIT_LOCK;
                    end else if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        state_n = RUN;
                    end
                end
                RUN: begin
                    if (!lock_s && filt == FILT_W'(UNLOCK_FILTER - 1)) begin
                        state_n    = PLLRST;
                        inc_relock = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Output and counter next values, derived from the upcoming state so the
    // registered outputs change in the same cycle as the state does
    always_comb begin
        pll_rst_n       = 1'b1;
        tx_rst_n        = 1'b1;
        video_en_n      = 1'b0;
        cnt_n           = '0;
        filt_n          = '0;
        relock_count_n  = relock_count;
        timeout_count_n = timeout_count;

        pll_rst_n  = (state_n == IDLE) || (state_n == PLLRST);
        tx_rst_n   = (state_n != RUN);
        video_en_n = (state_n == RUN) && (state == RUN);

        if (state_n == state && state != IDLE && state != RUN) begin
            cnt_n = cnt + CNT_W'(1);
        end
        if (state == RUN && state_n == RUN && !lock_s) begin
            filt_n = filt + FILT_W'(1);
        end
        if (inc_relock && relock_count != 8'hFF) begin
            relock_count_n = relock_count + 8'd1;
        end
        if (inc_timeout && timeout_count != 8'hFF) begin
            timeout_count_n = timeout_count + 8'd1;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_hdmi_clock_sequencer.sv
// Bench for hdmi_clock_sequencer: directed bring-up scenarios followed by
// randomized lock/enable/reset traffic, all checked against a cycle model.
module tb_hdmi_clock_sequencer;

    localparam int unsigned PRC = 4;
    localparam int unsigned LTO = 32;
    localparam int unsigned SC  = 8;
    localparam int unsigned UF  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       tx_rst;
    logic       video_en;
    logic [2:0] state_o;
    logic [7:0] relock_count;
    logic [7:0] timeout_count;

    int errors = 0;
    int checks = 0;

    // Reference model: phase number, cycles spent in the phase, RUN low streak
    int m_ph, m_t, m_low, m_rc, m_tc;
    bit m_s1, m_s2, m_pll, m_tx, m_ve;

    hdmi_clock_sequencer #(
        .PLL_RST_CYCLES(PRC),
        .LOCK_TIMEOUT  (LTO),
        .SETTLE_CYCLES (SC),
        .UNLOCK_FILTER (UF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .pll_locked   (pll_locked),
        .pll_rst      (pll_rst),
        .tx_rst       (tx_rst),
        .video_en     (video_en),
        .state_o      (state_o),
        .relock_count (relock_count),
        .timeout_count(timeout_count)
    );

    always #20 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Advance the model by one clock edge using the inputs sampled at that edge
    task automatic model_step();
        bit ls;
        int nph;
        if (reset) begin
            m_ph = 0; m_t = 0; m_low = 0; m_rc = 0; m_tc = 0;
            m_s1 = 0; m_s2 = 0; m_pll = 1; m_tx = 1; m_ve = 0;
        end else begin
            ls  = m_s2;
            nph = m_ph;
            if (m_ph != 0 && !enable) nph = 0;
            else begin
                case (m_ph)
                    0: if (enable) nph = 1;
                    1: if (m_t + 1 == PRC) nph = 2;
                    2: if (ls) nph = 3;
                       else if (m_t + 1 == LTO) begin
                           nph = 1;
                           if (m_tc < 255) m_tc++;
                       end
                    3: if (!ls) nph = 2;
                       else if (m_t + 1 == SC) nph = 4;
                    4: if (!ls && m_low + 1 == UF) begin
                           nph = 1;
                           if (m_rc < 255) m_rc++;
                       end
                    default: nph = 0;
                endcase
            end
            m_low = (m_ph == 4 && nph == 4 && !ls) ? m_low + 1 : 0;
            m_t   = (nph == m_ph) ? m_t + 1 : 0;
            m_ve  = (m_ph == 4 && nph == 4);
            m_tx  = (nph != 4);
            m_pll = (nph <= 1);
            m_ph  = nph;
            m_s2  = m_s1;
            m_s1  = pll_locked;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("m_state", 32'(state_o), 32'(m_ph));
        chk("m_pll_rst", 32'(pll_rst), 32'(m_pll));
        chk("m_tx_rst", 32'(tx_rst), 32'(m_tx));
        chk("m_video_en", 32'(video_en), 32'(m_ve));
        chk("m_relock", 32'(relock_count), 32'(m_rc));
        chk("m_timeout", 32'(timeout_count), 32'(m_tc));
    endtask

    task automatic wait_state(input logic [2:0] s, input int bound);
        int n;
        n = 0;
        while (state_o != s && n < bound) begin
            tick();
            n++;
        end
        chk("wait_state", 32'(state_o), 32'(s));
    endtask

    initial begin
        int n;
        int t_set, t_run;
        bit saw_abort;
        logic [2:0] prev;

        // Reset values
        repeat (3) tick();
        chk("rst_state", 32'(state_o), 0);
        chk("rst_pll_rst", 32'(pll_rst), 1);
        chk("rst_tx_rst", 32'(tx_rst), 1);
        chk("rst_video_en", 32'(video_en), 0);
        chk("rst_relock", 32'(relock_count), 0);
        chk("rst_timeout", 32'(timeout_count), 0);
        reset = 1'b0;
        tick();
        chk("idle_hold", 32'(state_o), 0);

        // Nominal bring-up
        enable = 1'b1;
        tick();
        chk("idle_to_pllrst", 32'(state_o), 1);
        n = 0;
        while (state_o == 3'd1 && n < 20) begin
            chk("pllrst_pll_high", 32'(pll_rst), 1);
            tick();
            n++;
        end
        chk("pllrst_len", 32'(n), 4);
        chk("wait_pll_low", 32'(pll_rst), 0);
        repeat (9) tick();
        pll_locked = 1'b1;
        tick();
        n = 0;
        while (state_o != 3'd4 && n < 50) begin
            tick();
            n++;
        end
        chk("lock_to_run", 32'(n), 10);
        chk("run_tx_low", 32'(tx_rst), 0);
        chk("run_ve_first", 32'(video_en), 0);
        tick();
        chk("run_ve_second", 32'(video_en), 1);
        chk("nominal_timeout", 32'(timeout_count), 0);

        // Two-cycle dropout is filtered
        repeat (4) tick();
        pll_locked = 1'b0;
        repeat (2) tick();
        pll_locked = 1'b1;
        repeat (6) tick();
        chk("glitch2_state", 32'(state_o), 4);
        chk("glitch2_relock", 32'(relock_count), 0);

        // Three-cycle dropout causes relock
        pll_locked = 1'b0;
        repeat (3) tick();
        pll_locked = 1'b1;
        n = 0;
        while (state_o == 3'd4 && n < 10) begin
            tick();
            n++;
        end
        chk("drop3_latency", 32'(n), 2);
        chk("drop3_state", 32'(state_o), 1);
        chk("drop3_tx_rst", 32'(tx_rst), 1);
        chk("drop3_video_en", 32'(video_en), 0);
        chk("drop3_relock", 32'(relock_count), 1);
        wait_state(3'd4, 60);

        // Enable drop from RUN, then restart
        enable = 1'b0;
        tick();
        chk("dis_state", 32'(state_o), 0);
        chk("dis_pll_rst", 32'(pll_rst), 1);
        chk("dis_tx_rst", 32'(tx_rst), 1);
        chk("dis_video_en", 32'(video_en), 0);
        enable = 1'b1;
        tick();
        chk("reen_state", 32'(state_o), 1);

        // Settle abort and full restart of the settle window
        pll_locked = 1'b0;
        wait_state(3'd2, 20);
        pll_locked = 1'b1;
        repeat (5) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        saw_abort = 1'b0;
        t_set = -1;
        t_run = -1;
        prev = state_o;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (prev == 3'd3 && state_o == 3'd2) saw_abort = 1'b1;
            if (saw_abort && prev == 3'd2 && state_o == 3'd3) t_set = i;
            if (state_o == 3'd4) begin
                t_run = i;
                break;
            end
            prev = state_o;
        end
        chk("abort_seen", 32'(saw_abort), 1);
        chk("resettle_len", 32'(t_run - t_set), 8);

        // Reset in the middle of SETTLE
        enable = 1'b0;
        tick();
        enable = 1'b1;
        pll_locked = 1'b0;
        wait_state(3'd2, 20);
        pll_locked = 1'b1;
        wait_state(3'd3, 10);
        tick();
        tick();
        chk("pre_rst_state", 32'(state_o), 3);
        chk("pre_rst_relock", 32'(relock_count), 1);
        reset = 1'b1;
        tick();
        chk("midrst_state", 32'(state_o), 0);
        chk("midrst_pll_rst", 32'(pll_rst), 1);
        chk("midrst_tx_rst", 32'(tx_rst), 1);
        chk("midrst_video_en", 32'(video_en), 0);
        chk("midrst_relock", 32'(relock_count), 0);
        chk("midrst_timeout", 32'(timeout_count), 0);
        reset = 1'b0;

        // No lock: timeouts until the counter saturates
        pll_locked = 1'b0;
        wait_state(3'd2, 20);
        n = 0;
        while (state_o == 3'd2 && n < 100) begin
            tick();
            n++;
        end
        chk("timeout_len", 32'(n), 32);
        chk("timeout_state", 32'(state_o), 1);
        chk("timeout_first", 32'(timeout_count), 1);
        for (int r = 1; r < 300; r++) begin
            wait_state(3'd2, 20);
            wait_state(3'd1, 40);
        end
        chk("timeout_sat", 32'(timeout_count), 255);

        // Randomized traffic against the model
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 11) == 0) pll_locked = ~pll_locked;
            enable = ($urandom_range(0, 199) != 0);
            reset  = ($urandom_range(0, 599) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
